// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan controller: segment codes, converter states, pow10 helper.
package fnd_pkg;

  // Active-low segment codes {dp,g,f,e,d,c,b,a} for digits 0..9, dp bit off; index 0 is rightmost.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // 10^n as a constant for overflow limits.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // BCD nibble to segment code; non-decimal nibbles render blank.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    return (d > 4'd9) ? SEG_BLANK : SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  conv_state_e       state, state_next;
  logic [DATA_W-1:0] bin_q, bin_n;
  logic [BCD_W-1:0]  bcd_n, corr_c;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  // Add-3 correction of every nibble that is 5 or more before the shift.
  always_comb begin
    corr_c = bcd;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (bcd[4*k +: 4] >= 4'd5) corr_c[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next = state;
    bin_n      = bin_q;
    bcd_n      = bcd;
    cnt_n      = cnt_q;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          state_next = CONV_SHIFT;
          bin_n      = value;
          bcd_n      = '0;
          cnt_n      = CNT_W'(DATA_W);
        end
      end
      CONV_SHIFT: begin
        bcd_n = {corr_c[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_n = {bin_q[DATA_W-2:0], 1'b0};
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_next = CONV_DONE;
      end
      CONV_DONE: state_next = CONV_IDLE;
      default:   state_next = CONV_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CONV_IDLE;
      bin_q <= '0;
      bcd   <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      bin_q <= bin_n;
      bcd   <= bcd_n;
      cnt_q <= cnt_n;
      busy  <= (state_next != CONV_IDLE);
      done  <= (state_next == CONV_DONE);
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment display driver: binary load, BCD conversion, digit scan with anti-ghost blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic                  ready,
  input  logic                  lz_blank_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_data
);

  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W    = $clog2(BLANK_CYCLES + 2);
  localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
  localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS) - 64'd1;

  // Reject illegal configurations at elaboration.
  if (SCAN_DIV < BLANK_CYCLES + 2) begin : g_bad_div
    $error("fnd_scan_controller: SCAN_DIV too small for BLANK_CYCLES");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("fnd_scan_controller: NUM_DIGITS must be 1..8");
  end
  if (DATA_W < 4 || DATA_W > 27) begin : g_bad_width
    $error("fnd_scan_controller: DATA_W must be 4..27");
  end

  logic [DIV_W-1:0]      div_q;
  logic [IDX_W-1:0]      idx;
  logic [BLK_W-1:0]      blank_cnt;
  logic [BCD_W-1:0]      display;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_busy, conv_done;
  logic                  ovf_pend;
  logic                  tick_c, start_c, zero_acc_c;
  logic [NUM_DIGITS-1:0] upper_zero_c, com_c;
  logic [3:0]            cur_digit_c;
  logic [7:0]            seg_c, data_c;

  assign tick_c  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign start_c = load && ready && !conv_busy;

  // Scan divider, digit index and post-advance blank window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      idx       <= '0;
      blank_cnt <= '0;
    end else begin
      div_q <= tick_c ? '0 : div_q + DIV_W'(1);
      if (tick_c) begin
        idx       <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        blank_cnt <= BLK_W'(BLANK_CYCLES);
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BLK_W'(1);
      end
    end
  end

  bin2bcd_seq #(
    .DATA_W    (DATA_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_conv (
    .clk  (clk),
    .rst_n(reset),
    .start(start_c),
    .value(value),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Load handshake; display and overflow change together when conversion completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready    <= 1'b1;
      ovf_pend <= 1'b0;
      overflow <= 1'b0;
      display  <= '0;
    end else if (start_c) begin
      ready    <= 1'b0;
      ovf_pend <= (64'(value) > OVF_LIMIT);
    end else if (conv_done) begin
      ready    <= 1'b1;
      overflow <= ovf_pend;
      display  <= conv_bcd;
    end
  end

  // Leading-zero map: bit k set when digits k..top are all zero.
  always_comb begin
    zero_acc_c   = 1'b1;
    upper_zero_c = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_acc_c      = zero_acc_c && (display[4*k +: 4] == 4'd0);
      upper_zero_c[k] = zero_acc_c;
    end
  end

  // Segment pattern and common select for the current digit.
  always_comb begin
    cur_digit_c = display[{idx, 2'b00} +: 4];
    if (overflow) begin
      seg_c = SEG_DASH;
    end else if (lz_blank_en && (idx != '0) && upper_zero_c[idx]) begin
      seg_c = SEG_BLANK;
    end else begin
      seg_c = seg_code(cur_digit_c);
    end
    data_c = {~dp_mask[idx], seg_c[6:0]};
    com_c  = (blank_cnt != '0) ? '1 : ~(NUM_DIGITS'(1) << idx);
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fnd_com  <= '1;
      fnd_data <= 8'hFF;
    end else begin
      fnd_com  <= com_c;
      fnd_data <= data_c;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with a cycle-count based reference model.
module tb_fnd_scan_controller;

  localparam int N  = 4;
  localparam int DW = 14;
  localparam int S  = 10;
  localparam int B  = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] value;
  logic          load;
  logic          ready;
  logic          lz_blank_en;
  logic [N-1:0]  dp_mask;
  logic          overflow;
  logic [N-1:0]  fnd_com;
  logic [7:0]    fnd_data;

  int checks = 0;
  int errors = 0;

  fnd_scan_controller #(
    .NUM_DIGITS  (N),
    .DATA_W      (DW),
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .BLANK_CYCLES(B)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .ready      (ready),
    .lz_blank_en(lz_blank_en),
    .dp_mask    (dp_mask),
    .overflow   (overflow),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data)
  );

  always #5 clk = ~clk;

  // Reference model state: edges since reset release, pending and shown values.
  int         t;
  bit         m_busy;
  int         m_done_t;
  int         m_pend_val;
  bit         m_pend_ovf;
  int         m_disp_val;
  bit         m_disp_ovf;
  logic [N-1:0] exp_com;
  logic [7:0]   exp_data;
  logic         exp_ready;
  logic         exp_ovf;

  function automatic int p10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Commons after a given number of elapsed edges: blank right after each advance, else one-hot-zero.
  function automatic logic [N-1:0] model_com(input int tp);
    int k;
    if (tp >= S && (tp % S) < B) return '1;
    k = (tp / S) % N;
    return ~(N'(1) << k);
  endfunction

  function automatic logic [7:0] model_data(input int tp, input int val, input bit ovf,
                                            input bit lz, input logic [N-1:0] dp);
    int k;
    logic [7:0] sg;
    k = (tp / S) % N;
    if (ovf) sg = 8'hBF;
    else if (lz && k != 0 && val < p10(k)) sg = 8'hFF;
    else sg = seg_of((val / p10(k)) % 10);
    return {~dp[k], sg[6:0]};
  endfunction

  // Reference model advanced once per clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t          <= 0;
      m_busy     <= 1'b0;
      m_done_t   <= 0;
      m_pend_val <= 0;
      m_pend_ovf <= 1'b0;
      m_disp_val <= 0;
      m_disp_ovf <= 1'b0;
      exp_com    <= '1;
      exp_data   <= 8'hFF;
      exp_ready  <= 1'b1;
      exp_ovf    <= 1'b0;
    end else begin
      exp_com  <= model_com(t);
      exp_data <= model_data(t, m_disp_val, m_disp_ovf, lz_blank_en, dp_mask);
      t        <= t + 1;
      if (load && !m_busy) begin
        m_busy     <= 1'b1;
        m_done_t   <= t + 1 + DW + 1;
        m_pend_val <= int'(value);
        m_pend_ovf <= (int'(value) > p10(N) - 1);
        exp_ready  <= 1'b0;
        exp_ovf    <= m_disp_ovf;
      end else if (m_busy && (t + 1 == m_done_t)) begin
        m_busy     <= 1'b0;
        m_disp_val <= m_pend_val;
        m_disp_ovf <= m_pend_ovf;
        exp_ready  <= 1'b1;
        exp_ovf    <= m_pend_ovf;
      end else begin
        exp_ready <= !m_busy;
        exp_ovf   <= m_disp_ovf;
      end
    end
  end

  task automatic pulse_load(input logic [DW-1:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; value = '0; lz_blank_en = 1'b0; dp_mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data, ready, overflow} !== {4'hF, 8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got com=%b data=%h ready=%b ovf=%b, expected com=1111 data=ff ready=1 ovf=0",
               fnd_com, fnd_data, ready, overflow);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({fnd_com, fnd_data} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("FAIL first_scan: got com=%b data=%h, expected com=1110 data=c0", fnd_com, fnd_data);
    end
  endtask

  task automatic test_convert();
    logic [7:0] want;
    lz_blank_en = 1'b0; dp_mask = '0;
    pulse_load(14'd1234);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_drop: got ready=%b, expected 0", ready);
    end
    for (int i = 1; i <= DW + 1; i++) begin
      @(negedge clk);
      checks++;
      if (ready !== (i == DW + 1)) begin
        errors++;
        $display("FAIL ready_latency cycle %0d: got ready=%b, expected %b", i, ready, (i == DW + 1));
      end
    end
    repeat (4 * S + 5) begin
      @(negedge clk);
      checks++;
      if ({fnd_com, fnd_data, ready, overflow} !== {exp_com, exp_data, exp_ready, exp_ovf}) begin
        errors++;
        $display("FAIL convert_scan: got %b/%h/%b/%b expected %b/%h/%b/%b",
                 fnd_com, fnd_data, ready, overflow, exp_com, exp_data, exp_ready, exp_ovf);
      end
      case (fnd_com)
        4'b1110: want = 8'h99;
        4'b1101: want = 8'hB0;
        4'b1011: want = 8'hA4;
        4'b0111: want = 8'hF9;
        default: want = fnd_data;
      endcase
      if (fnd_com != 4'hF) begin
        checks++;
        if (fnd_data !== want) begin
          errors++;
          $display("FAIL digits_1234 com=%b: got data=%h, expected %h", fnd_com, fnd_data, want);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [DW-1:0] vals [2];
    logic [7:0]    d0   [2];
    vals[0] = 14'd7; vals[1] = 14'd0;
    d0[0]   = 8'hF8; d0[1]   = 8'hC0;
    lz_blank_en = 1'b1; dp_mask = '0;
    for (int v = 0; v < 2; v++) begin
      pulse_load(vals[v]);
      repeat (DW + 1 + 4 * S + 5) begin
        @(negedge clk);
        checks++;
        if ({fnd_com, fnd_data, ready, overflow} !== {exp_com, exp_data, exp_ready, exp_ovf}) begin
          errors++;
          $display("FAIL lz_scan: got %b/%h/%b/%b expected %b/%h/%b/%b",
                   fnd_com, fnd_data, ready, overflow, exp_com, exp_data, exp_ready, exp_ovf);
        end
      end
      repeat (4 * S) begin
        @(negedge clk);
        if (fnd_com != 4'hF) begin
          checks++;
          if (fnd_data !== ((fnd_com == 4'b1110) ? d0[v] : 8'hFF)) begin
            errors++;
            $display("FAIL lz_digit val=%0d com=%b: got data=%h", vals[v], fnd_com, fnd_data);
          end
        end
      end
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] vals [2];
    logic [7:0]    seg  [2];
    logic          ovf  [2];
    vals[0] = 14'd12000; seg[0] = 8'hBF; ovf[0] = 1'b1;
    vals[1] = 14'd9999;  seg[1] = 8'h90; ovf[1] = 1'b0;
    lz_blank_en = 1'b1; dp_mask = '0;
    for (int v = 0; v < 2; v++) begin
      pulse_load(vals[v]);
      repeat (DW + 1) @(negedge clk);
      checks++;
      if (overflow !== ovf[v]) begin
        errors++;
        $display("FAIL overflow_flag val=%0d: got %b, expected %b", vals[v], overflow, ovf[v]);
      end
      repeat (4 * S + 5) begin
        @(negedge clk);
        checks++;
        if ({fnd_com, fnd_data, overflow} !== {exp_com, exp_data, exp_ovf}) begin
          errors++;
          $display("FAIL overflow_scan: got %b/%h/%b expected %b/%h/%b",
                   fnd_com, fnd_data, overflow, exp_com, exp_data, exp_ovf);
        end
        if (fnd_com != 4'hF) begin
          checks++;
          if (fnd_data !== seg[v]) begin
            errors++;
            $display("FAIL overflow_digit val=%0d: got data=%h, expected %h", vals[v], fnd_data, seg[v]);
          end
        end
      end
    end
    lz_blank_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    lz_blank_en = 1'b0; dp_mask = '0;
    pulse_load(14'd1234);
    @(negedge clk);
    value = 14'd5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    dp_mask = 4'b0100;
    repeat (DW + 4 * S + 5) begin
      @(negedge clk);
      checks++;
      if ({fnd_com, fnd_data, ready, overflow} !== {exp_com, exp_data, exp_ready, exp_ovf}) begin
        errors++;
        $display("FAIL b2b_scan: got %b/%h/%b/%b expected %b/%h/%b/%b",
                 fnd_com, fnd_data, ready, overflow, exp_com, exp_data, exp_ready, exp_ovf);
      end
    end
    repeat (4 * S) begin
      @(negedge clk);
      case (fnd_com)
        4'b1110: want = 8'h99;
        4'b1101: want = 8'hB0;
        4'b1011: want = 8'h24;
        4'b0111: want = 8'hF9;
        default: want = fnd_data;
      endcase
      if (fnd_com != 4'hF) begin
        checks++;
        if (fnd_data !== want) begin
          errors++;
          $display("FAIL b2b_digit com=%b: got data=%h, expected %h", fnd_com, fnd_data, want);
        end
      end
    end
    dp_mask = '0;
  endtask

  task automatic test_reset_mid();
    lz_blank_en = 1'b0; dp_mask = '0;
    pulse_load(14'(4321));
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({fnd_com, fnd_data, ready, overflow} !== {4'hF, 8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: got com=%b data=%h ready=%b ovf=%b, expected 1111/ff/1/0",
               fnd_com, fnd_data, ready, overflow);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (DW + 4 * S) begin
      @(negedge clk);
      checks++;
      if ({fnd_com, fnd_data, ready, overflow} !== {exp_com, exp_data, exp_ready, exp_ovf}) begin
        errors++;
        $display("FAIL reset_mid_scan: got %b/%h/%b/%b expected %b/%h/%b/%b",
                 fnd_com, fnd_data, ready, overflow, exp_com, exp_data, exp_ready, exp_ovf);
      end
      if (fnd_com != 4'hF) begin
        checks++;
        if ({fnd_data, ready} !== {8'hC0, 1'b1}) begin
          errors++;
          $display("FAIL reset_mid_zero: got data=%h ready=%b, expected c0/1", fnd_data, ready);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(negedge clk);
      checks++;
      if ({fnd_com, fnd_data, ready, overflow} !== {exp_com, exp_data, exp_ready, exp_ovf}) begin
        errors++;
        $display("FAIL random_scan t=%0d: got %b/%h/%b/%b expected %b/%h/%b/%b",
                 t, fnd_com, fnd_data, ready, overflow, exp_com, exp_data, exp_ready, exp_ovf);
      end
      load  = ($urandom_range(0, 3) == 0);
      value = DW'($urandom_range(0, 16383));
      if ($urandom_range(0, 15) == 0) begin
        lz_blank_en = 1'($urandom_range(0, 1));
        dp_mask     = N'($urandom);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_convert();
    test_lz_blank();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
